maj_voter_tmr: RTL and testbench

//  Registered, parametrised triple-modular-redundancy bitwise majority voter with per-channel fault tracking.

---
 rtl/maj_voter_pkg.sv | 16 +
 rtl/maj_chan_monitor.sv | 85 ++++++++
 rtl/maj_voter_tmr.sv | 99 +++++++++
 tb/tb_maj_voter_tmr.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/maj_voter_pkg.sv
// Shared types and helpers for the TMR majority voter.
package maj_voter_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    HLTH_OK     = 2'd0,
    HLTH_SINGLE = 2'd1,
    HLTH_MULTI  = 2'd2
  } health_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/maj_chan_monitor.sv
// Per-channel disagreement streak tracker with sticky fault latch.
// Optional saturating error counter when MAJ_VOTER_ERRCNT_EN is defined.
module maj_chan_monitor #(
  parameter int PERSIST = 3
`ifdef MAJ_VOTER_ERRCNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic mis,
  input  logic clr_fault,
  output logic fault,
  output logic fault_next
`ifdef MAJ_VOTER_ERRCNT_EN
  , output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int SW = $clog2(PERSIST + 1);
  localparam logic [SW-1:0] PMAX = SW'(PERSIST);

  logic [SW-1:0] streak_r, streak_nxt_s;
  logic          fault_r, fault_nxt_s;

  // Next streak/fault; clr_fault wins over detection on the same sample.
  always_comb begin
    streak_nxt_s = streak_r;
    fault_nxt_s  = fault_r;
    if (clr_fault) begin
      streak_nxt_s = '0;
      fault_nxt_s  = 1'b0;
    end else if (valid) begin
      if (mis) begin
        if (streak_r != PMAX) begin
          streak_nxt_s = streak_r + SW'(1);
        end else begin
          streak_nxt_s = streak_r;
        end
      end else begin
        streak_nxt_s = '0;
      end
      if (streak_nxt_s == PMAX) begin
        fault_nxt_s = 1'b1;
      end else begin
        fault_nxt_s = fault_r;
      end
    end else begin
      streak_nxt_s = streak_r;
      fault_nxt_s  = fault_r;
    end
  end

  // Streak and fault state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_r <= '0;
      fault_r  <= 1'b0;
    end else begin
      streak_r <= streak_nxt_s;
      fault_r  <= fault_nxt_s;
    end
  end

  assign fault      = fault_r;
  assign fault_next = fault_nxt_s;

`ifdef MAJ_VOTER_ERRCNT_EN
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] cnt_r;

  // Saturating error counter; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (valid && mis && (cnt_r != CMAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign err_cnt = cnt_r;
`endif

endmodule

// File: rtl/maj_voter_tmr.sv
// Registered TMR bitwise majority voter with per-channel fault tracking and health FSM.
// Define MAJ_VOTER_ERRCNT_EN to add per-channel saturating error counters on err_cnt.
module maj_voter_tmr
  import maj_voter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_fault,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       mismatch,
  output logic [2:0]       fault,
  output logic [1:0]       state
`ifdef MAJ_VOTER_ERRCNT_EN
  , output logic [3*CNT_W-1:0] err_cnt
`endif
);

  logic [WIDTH-1:0]  vote_s;
  logic [NUM_CH-1:0] mis_s;
  logic [NUM_CH-1:0] fault_s;
  logic [NUM_CH-1:0] fault_nxt_s;
  logic [WIDTH-1:0]  y_r;
  logic [2:0]        mismatch_r;
  logic              out_valid_r;
  health_e           state_r, state_nxt_s;

  assign vote_s = (a & b) | (b & c) | (c & a);
  assign mis_s  = {|(c ^ vote_s), |(b ^ vote_s), |(a ^ vote_s)};

  // Output data registers; y and mismatch hold across invalid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r         <= '0;
      mismatch_r  <= 3'b000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        y_r        <= vote_s;
        mismatch_r <= mis_s;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_mon
    maj_chan_monitor #(
      .PERSIST(PERSIST)
`ifdef MAJ_VOTER_ERRCNT_EN
      , .CNT_W(CNT_W)
`endif
    ) u_mon (
      .clk        (clk),
      .rst        (rst),
      .valid      (in_valid),
      .mis        (mis_s[i]),
      .clr_fault  (clr_fault),
      .fault      (fault_s[i]),
      .fault_next (fault_nxt_s[i])
`ifdef MAJ_VOTER_ERRCNT_EN
      , .err_cnt  (err_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

  // Health decode from next-cycle fault set so state lines up with fault.
  always_comb begin
    state_nxt_s = HLTH_OK;
    case (popcount3(fault_nxt_s))
      2'd0:    state_nxt_s = HLTH_OK;
      2'd1:    state_nxt_s = HLTH_SINGLE;
      default: state_nxt_s = HLTH_MULTI;
    endcase
  end

  // Health state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HLTH_OK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign y         = y_r;
  assign mismatch  = mismatch_r;
  assign out_valid = out_valid_r;
  assign fault     = fault_s;
  assign state     = state_r;

endmodule

// File: tb/tb_maj_voter_tmr.sv
// Directed table-driven bench for maj_voter_tmr (WIDTH=8, PERSIST=3, CNT_W=4).
module tb_maj_voter_tmr;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a, b, c;
  logic             clr_fault;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic [2:0]       mismatch;
  logic [2:0]       fault;
  logic [1:0]       state;
`ifdef MAJ_VOTER_ERRCNT_EN
  logic [3*CNT_W-1:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maj_voter_tmr #(.WIDTH(WIDTH), .PERSIST(3), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .clr_fault (clr_fault),
    .out_valid (out_valid),
    .y         (y),
    .mismatch  (mismatch),
    .fault     (fault),
    .state     (state)
`ifdef MAJ_VOTER_ERRCNT_EN
    , .err_cnt (err_cnt)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] a, b, c;
    logic       clr;
    logic       ov;
    logic [7:0] y;
    logic [2:0] mis;
    logic [2:0] flt;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ic, input logic clr, input logic r);
    @(negedge clk);
    in_valid  = v;
    a         = ia;
    b         = ib;
    c         = ic;
    clr_fault = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [7:0] ey,
                         input logic [2:0] em, input logic [2:0] ef, input logic [1:0] es);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " y"},         32'(y),         32'(ey));
    chk({tag, " mismatch"},  32'(mismatch),  32'(em));
    chk({tag, " fault"},     32'(fault),     32'(ef));
    chk({tag, " state"},     32'(state),     32'(es));
  endtask

  initial begin
    // v, a, b, c, clr | ov, y, mis, fault, state
    tbl.push_back('{1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b1, 8'hA5, 3'b000, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'hFF, 3'b110, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'b100, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'b100, 3'b100, 2'd1});
    tbl.push_back('{1'b0, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h00, 3'b100, 3'b100, 2'd1});
    // b: two mismatches then a match -> no fault
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b100, 2'd1});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b100, 2'd1});
    tbl.push_back('{1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b1, 8'h3C, 3'b000, 3'b100, 2'd1});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b100, 2'd1});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b100, 2'd1});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b110, 2'd2});
    // clr_fault: MULTI -> OK; clr overrides detection on a mismatching sample
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 3'b010, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 3'b010, 3'b010, 2'd1});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 3'b010, 3'b000, 2'd0});
    // in_valid gaps inside a streak on c
    tbl.push_back('{1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'b100, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 3'b100, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'b100, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 3'b100, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 3'b100, 3'b000, 2'd0});
    tbl.push_back('{1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 3'b100, 3'b100, 2'd1});
    // all-different per bit: 0x0C,0x0A,0x06 -> majority 0x0E; every channel differs
    tbl.push_back('{1'b1, 8'h0C, 8'h0A, 8'h06, 1'b0, 1'b1, 8'h0E, 3'b111, 3'b100, 2'd1});

    in_valid = 1'b0; a = '0; b = '0; c = '0; clr_fault = 1'b0; rst = 1'b1;
    step(1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    chk_all("reset", 1'b0, 8'h00, 3'b000, 3'b000, 2'd0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr, 1'b0);
      chk_all($sformatf("row%0d", i), tbl[i].ov, tbl[i].y, tbl[i].mis, tbl[i].flt, tbl[i].st);
    end

    // rst mid-streak on b with valid data present: outputs return to reset values
    step(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
    chk_all("midrst", 1'b0, 8'h00, 3'b000, 3'b000, 2'd0);
    // streak must restart from zero after reset
    step(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk_all("postrst2", 1'b1, 8'h00, 3'b010, 3'b000, 2'd0);
    step(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk_all("postrst3", 1'b1, 8'h00, 3'b010, 3'b010, 2'd1);

`ifdef MAJ_VOTER_ERRCNT_EN
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("errcnt reset", 32'(err_cnt), 32'h0);
    for (int k = 0; k < 5; k++) step(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("errcnt 5", 32'(err_cnt), 32'h005);
    for (int k = 0; k < 15; k++) step(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("errcnt sat", 32'(err_cnt), 32'h00F);
    chk("errcnt fault", 32'(fault), 32'h1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("errcnt after clr", 32'(err_cnt), 32'h00F);
    chk("fault after clr", 32'(fault), 32'h0);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("errcnt after rst", 32'(err_cnt), 32'h000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
